// File: rtl/sdram_capture_writer.sv
// sdram_capture_writer: channel-filtered ADC sample packer, show-ahead word
// FIFO and burst writer into a wrapping SDRAM region.
// Optional build macro: CAPTURE_TEST_PATTERN_EN replaces sample_data with a
// per-capture SAMPLE_W-bit counter that advances on every accepted sample.
module sdram_capture_writer #(
  parameter int unsigned  NUM_CH       = 4,
  parameter int unsigned  SAMPLE_W     = 16,
  parameter int unsigned  FIFO_DEPTH   = 16,
  parameter int unsigned  BURST_BYTES  = 64,
  parameter logic [31:0]  REGION_BYTES = 32'h0100_0000,
  localparam int unsigned CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                stop_write,
  input  logic [31:0]         num_bytes,
  input  logic [31:0]         base_addr,
  input  logic [NUM_CH-1:0]   ch_en,
  input  logic                sample_valid,
  input  logic [CH_W-1:0]     sample_ch,
  input  logic [SAMPLE_W-1:0] sample_data,
  input  logic                write_buffer_full,
  input  logic                write_control_done,
  output logic                write_control_fixed_location,
  output logic [31:0]         control_write_base,
  output logic [31:0]         control_write_length,
  output logic                write_control_go,
  output logic                user_data_valid,
  output logic [31:0]         user_write_buffer_data,
  output logic                busy,
  output logic                capture_done,
  output logic                overflow,
  output logic [31:0]         bytes_written
);

  localparam int unsigned SPW     = 32 / SAMPLE_W;
  localparam int unsigned CW      = (SPW > 1) ? $clog2(SPW) : 1;
  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam int unsigned PW      = AW + 1;
  localparam int unsigned PACK_W  = 32 - SAMPLE_W;
  localparam logic [31:0] BURST_B = 32'(BURST_BYTES);

  typedef enum logic [1:0] {S_IDLE, S_GO, S_DATA, S_WAIT} state_t;

  state_t              state, state_nxt;
  logic                start_cap, next_burst, finish;
  logic [31:0]         base_q, num_q, cur_addr, remaining, len_q, burst_left, pushed_bytes;
  logic [NUM_CH-1:0]   ch_en_q;
  logic [31:0]         rem_nxt, addr_nxt;
  logic [32:0]         addr_sum, region_end;
  logic [PACK_W-1:0]   pack_q;
  logic [CW-1:0]       cnt_q;
  logic [31:0]         word_q, word_nxt;
  logic                word_pend_q, accept, smp_last;
  logic [SAMPLE_W-1:0] smp;
  logic [31:0]         mem [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic                fifo_empty, fifo_full, push;

  function automatic logic [31:0] burst_len(input logic [31:0] r);
    return (r < BURST_B) ? r : BURST_B;
  endfunction

  assign write_control_fixed_location = 1'b0;
  assign busy             = (state != S_IDLE);
  assign write_control_go = (state == S_GO);
  assign control_write_base   = cur_addr;
  assign control_write_length = len_q;

  // Next burst address and remaining byte count, wrapping inside the region
  assign rem_nxt    = remaining - len_q;
  assign addr_sum   = {1'b0, cur_addr} + {1'b0, len_q};
  assign region_end = {1'b0, base_q} + {1'b0, REGION_BYTES};
  assign addr_nxt   = (addr_sum >= region_end) ? base_q : addr_sum[31:0];

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic and capture control strobes
  always_comb begin
    state_nxt  = state;
    start_cap  = 1'b0;
    next_burst = 1'b0;
    finish     = 1'b0;
    case (state)
      S_IDLE: if (start && !stop_write) begin
        state_nxt = S_GO;
        start_cap = 1'b1;
      end
      S_GO:   state_nxt = S_DATA;
      S_DATA: if (burst_left == 32'd0) state_nxt = S_WAIT;
      S_WAIT: if (write_control_done) begin
        if (rem_nxt == 32'd0 || stop_write) begin
          state_nxt = S_IDLE;
          finish    = 1'b1;
        end else begin
          state_nxt  = S_GO;
          next_burst = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Burst bookkeeping, byte counters and completion pulse
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      base_q        <= '0;
      num_q         <= '0;
      ch_en_q       <= '0;
      cur_addr      <= '0;
      remaining     <= '0;
      len_q         <= '0;
      burst_left    <= '0;
      bytes_written <= '0;
      capture_done  <= 1'b0;
    end else begin
      capture_done <= finish;
      if (start_cap) begin
        base_q        <= base_addr;
        num_q         <= num_bytes;
        ch_en_q       <= ch_en;
        cur_addr      <= base_addr;
        remaining     <= num_bytes;
        len_q         <= burst_len(num_bytes);
        burst_left    <= burst_len(num_bytes);
        bytes_written <= '0;
      end else if (next_burst) begin
        remaining  <= rem_nxt;
        cur_addr   <= addr_nxt;
        len_q      <= burst_len(rem_nxt);
        burst_left <= burst_len(rem_nxt);
      end else if (user_data_valid) begin
        burst_left    <= burst_left - 32'd4;
        bytes_written <= bytes_written + 32'd4;
      end
    end
  end

`ifdef CAPTURE_TEST_PATTERN_EN
  logic [SAMPLE_W-1:0] tp_cnt;
  logic                unused_sample_data;
  assign unused_sample_data = ^sample_data;
  assign smp = tp_cnt;

  // Test-pattern counter, restarted on every capture
  always_ff @(posedge clk) begin
    if (!reset_n)       tp_cnt <= '0;
    else if (start_cap) tp_cnt <= '0;
    else if (accept)    tp_cnt <= tp_cnt + SAMPLE_W'(1);
  end
`else
  assign smp = sample_data;
`endif

  assign accept   = sample_valid && busy && ch_en_q[sample_ch] && (pushed_bytes < num_q);
  assign smp_last = (cnt_q == CW'(SPW - 1));
  assign word_nxt = {pack_q, smp};

  // Sample packer: first sample lands in the MSBs; partial words die at stop
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pack_q       <= '0;
      cnt_q        <= '0;
      word_q       <= '0;
      word_pend_q  <= 1'b0;
      pushed_bytes <= '0;
    end else begin
      word_pend_q <= 1'b0;
      if (start_cap || finish) begin
        pack_q <= '0;
        cnt_q  <= '0;
        if (start_cap) pushed_bytes <= '0;
      end else if (accept) begin
        pack_q <= word_nxt[PACK_W-1:0];
        if (smp_last) begin
          cnt_q        <= '0;
          word_q       <= word_nxt;
          word_pend_q  <= 1'b1;
          pushed_bytes <= pushed_bytes + 32'd4;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end
  end

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push       = word_pend_q && !fifo_full;

  assign user_data_valid = (state == S_DATA) && !fifo_empty && !write_buffer_full &&
                           (burst_left != 32'd0);
  assign user_write_buffer_data = fifo_empty ? 32'd0 : mem[rd_ptr[AW-1:0]];

  // FIFO pointers and sticky overflow; a word pushed into a full FIFO is lost
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else if (start_cap) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push)                       wr_ptr   <= wr_ptr + PW'(1);
      if (word_pend_q && fifo_full)   overflow <= 1'b1;
      if (user_data_valid)            rd_ptr   <= rd_ptr + PW'(1);
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= word_q;
  end

endmodule

// File: tb/tb_sdram_capture_writer.sv
// Directed bench for sdram_capture_writer with a small write-master model.
module tb_sdram_capture_writer;

  localparam logic [31:0] REGION = 32'd256;

  logic        clk, reset_n, start, stop_write;
  logic [31:0] num_bytes, base_addr;
  logic [3:0]  ch_en;
  logic        sample_valid;
  logic [1:0]  sample_ch;
  logic [15:0] sample_data;
  logic        write_buffer_full, write_control_done;
  logic        write_control_fixed_location, write_control_go, user_data_valid;
  logic [31:0] control_write_base, control_write_length, user_write_buffer_data;
  logic        busy, capture_done, overflow;
  logic [31:0] bytes_written;

  sdram_capture_writer #(
    .NUM_CH(4), .SAMPLE_W(16), .FIFO_DEPTH(16), .BURST_BYTES(64), .REGION_BYTES(REGION)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop_write(stop_write),
    .num_bytes(num_bytes), .base_addr(base_addr), .ch_en(ch_en),
    .sample_valid(sample_valid), .sample_ch(sample_ch), .sample_data(sample_data),
    .write_buffer_full(write_buffer_full), .write_control_done(write_control_done),
    .write_control_fixed_location(write_control_fixed_location),
    .control_write_base(control_write_base), .control_write_length(control_write_length),
    .write_control_go(write_control_go), .user_data_valid(user_data_valid),
    .user_write_buffer_data(user_write_buffer_data), .busy(busy),
    .capture_done(capture_done), .overflow(overflow), .bytes_written(bytes_written)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] go_base_q[$];
  logic [31:0] go_len_q[$];
  logic [31:0] data_q[$];
  int          cur_cnt = 0;
  logic [31:0] cur_len = 32'd0;
  bit          burst_open = 1'b0;
  int          full_strobes = 0;

  // Observe burst launches and data strobes between clock edges
  initial forever begin
    @(negedge clk);
    if (reset_n) begin
      if (write_control_go) begin
        go_base_q.push_back(control_write_base);
        go_len_q.push_back(control_write_length);
        cur_len    = control_write_length;
        cur_cnt    = 0;
        burst_open = 1'b1;
      end
      if (user_data_valid) begin
        data_q.push_back(user_write_buffer_data);
        cur_cnt++;
        if (write_buffer_full) full_strobes++;
      end
    end
  end

  // Write master: report done two cycles after the last word of a burst
  initial begin
    write_control_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (burst_open && cur_len != 32'd0 && 32'(cur_cnt * 4) == cur_len) begin
        burst_open = 1'b0;
        @(posedge clk); #1;
        write_control_done = 1'b1;
        @(posedge clk); #1;
        write_control_done = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pick(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic clear_log();
    go_base_q.delete();
    go_len_q.delete();
    data_q.delete();
    cur_cnt      = 0;
    cur_len      = 32'd0;
    burst_open   = 1'b0;
    full_strobes = 0;
  endtask

  task automatic do_start(input logic [31:0] nb, input logic [31:0] ba, input logic [3:0] en);
    @(posedge clk); #1;
    num_bytes = nb; base_addr = ba; ch_en = en; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [1:0] ch, input logic [15:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      sample_valid = 1'b1;
      sample_ch    = ch;
      sample_data  = first + 16'(i);
    end
    @(posedge clk); #1;
    sample_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (capture_done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_capture_done"}, 32'(seen), 32'd1);
    @(negedge clk);
    chk({tag, "_done_pulse_width"}, 32'(capture_done), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; stop_write = 1'b0;
    num_bytes = '0; base_addr = '0; ch_en = '0;
    sample_valid = 1'b0; sample_ch = '0; sample_data = '0;
    write_buffer_full = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_go", 32'(write_control_go), 32'd0);
    chk("rst_valid", 32'(user_data_valid), 32'd0);
    chk("rst_data", user_write_buffer_data, 32'd0);
    chk("rst_base", control_write_base, 32'd0);
    chk("rst_len", control_write_length, 32'd0);
    chk("rst_bytes", bytes_written, 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_fixed", 32'(write_control_fixed_location), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // 1: single 64-byte burst, ch1 samples filtered out
    clear_log();
    do_start(32'd64, 32'h0000_1000, 4'b0001);
    send(2'd1, 16'hBEE0, 4);
    send(2'd0, 16'h0001, 32);
    wait_done("t1");
    chk("t1_nbursts", 32'(go_base_q.size()), 32'd1);
    chk("t1_base", pick(go_base_q, 0), 32'h0000_1000);
    chk("t1_len", pick(go_len_q, 0), 32'd64);
    chk("t1_nwords", 32'(data_q.size()), 32'd16);
    chk("t1_word0", pick(data_q, 0), 32'h0001_0002);
    chk("t1_word15", pick(data_q, 15), 32'h001F_0020);
    chk("t1_bytes", bytes_written, 32'd64);
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_ovf", 32'(overflow), 32'd0);

    // 2: 160 bytes -> bursts 64, 64, 32
    clear_log();
    do_start(32'd160, 32'h0000_2000, 4'b0001);
    send(2'd0, 16'h0200, 80);
    wait_done("t2");
    chk("t2_nbursts", 32'(go_base_q.size()), 32'd3);
    chk("t2_base1", pick(go_base_q, 1), 32'h0000_2040);
    chk("t2_base2", pick(go_base_q, 2), 32'h0000_2080);
    chk("t2_len1", pick(go_len_q, 1), 32'd64);
    chk("t2_len2", pick(go_len_q, 2), 32'd32);
    chk("t2_word39", pick(data_q, 39), 32'h024E_024F);
    chk("t2_bytes", bytes_written, 32'd160);

    // 3: region wrap with a 256-byte region and 384 bytes captured
    clear_log();
    do_start(32'd384, 32'h0000_0000, 4'b0100);
    send(2'd2, 16'h1000, 192);
    wait_done("t3");
    chk("t3_nbursts", 32'(go_base_q.size()), 32'd6);
    chk("t3_base3", pick(go_base_q, 3), 32'h0000_00C0);
    chk("t3_base4", pick(go_base_q, 4), 32'h0000_0000);
    chk("t3_base5", pick(go_base_q, 5), 32'h0000_0040);
    chk("t3_bytes", bytes_written, 32'd384);

    // 4: master buffer full while 20 words arrive -> 4 dropped, no strobes
    clear_log();
    write_buffer_full = 1'b1;
    do_start(32'd128, 32'h0000_3000, 4'b0010);
    send(2'd1, 16'h0300, 40);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("t4_no_valid_full", 32'(user_data_valid), 32'd0);
    chk("t4_ovf", 32'(overflow), 32'd1);
    chk("t4_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    stop_write = 1'b1;
    write_buffer_full = 1'b0;
    wait_done("t4");
    stop_write = 1'b0;
    chk("t4_full_strobes", 32'(full_strobes), 32'd0);
    chk("t4_len", pick(go_len_q, 0), 32'd64);
    chk("t4_nwords", 32'(data_q.size()), 32'd16);
    chk("t4_word0", pick(data_q, 0), 32'h0300_0301);
    chk("t4_word15", pick(data_q, 15), 32'h031E_031F);
    chk("t4_bytes", bytes_written, 32'd64);
    chk("t4_ovf_sticky", 32'(overflow), 32'd1);

    // 5: stop during burst 1 of 3 -> burst finishes, then idle
    clear_log();
    do_start(32'd192, 32'h0000_4000, 4'b0001);
    send(2'd0, 16'h0400, 8);
    stop_write = 1'b1;
    send(2'd0, 16'h0408, 24);
    wait_done("t5");
    chk("t5_nbursts", 32'(go_base_q.size()), 32'd1);
    chk("t5_bytes", bytes_written, 32'd64);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_ovf_cleared", 32'(overflow), 32'd0);
    do_start(32'd64, 32'h0000_4800, 4'b0001);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t5_start_with_stop_busy", 32'(busy), 32'd0);
    chk("t5_start_with_stop_go", 32'(go_base_q.size()), 32'd1);
    stop_write = 1'b0;

    // 6: reset for one cycle mid-burst, then a clean capture
    clear_log();
    do_start(32'd64, 32'h0000_5000, 4'b0001);
    send(2'd0, 16'h0500, 10);
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_valid", 32'(user_data_valid), 32'd0);
    chk("t6_data", user_write_buffer_data, 32'd0);
    chk("t6_base", control_write_base, 32'd0);
    chk("t6_len", control_write_length, 32'd0);
    chk("t6_bytes", bytes_written, 32'd0);
    clear_log();
    do_start(32'd64, 32'h0000_6000, 4'b1000);
    send(2'd3, 16'h0A00, 32);
    wait_done("t6");
    chk("t6_new_base", pick(go_base_q, 0), 32'h0000_6000);
    chk("t6_new_len", pick(go_len_q, 0), 32'd64);
    chk("t6_new_word0", pick(data_q, 0), 32'h0A00_0A01);
    chk("t6_new_nwords", 32'(data_q.size()), 32'd16);
    chk("t6_new_bytes", bytes_written, 32'd64);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
